// File: rtl/input_cond_pkg.sv
// rtl/input_cond_pkg.sv - shared constants and helpers for the input conditioner
package input_cond_pkg;

    localparam int unsigned TICK_CYCLES_DEF    = 250000;
    localparam int unsigned STABLE_SAMPLES_DEF = 4;

    localparam int unsigned NUM_DIGITS    = 10;
    localparam int unsigned NUM_BTNS      = 5;
    localparam int unsigned NUM_PULSE_BTN = 4;

    localparam logic [3:0] KEY_NONE = 4'hF;

    // Button channel indices; the four pulse buttons come first so they
    // can share one contiguous edge-detect vector.
    localparam int unsigned SET       = 0;
    localparam int unsigned CONFIRM   = 1;
    localparam int unsigned BACKSPACE = 2;
    localparam int unsigned ADMIN_RST = 3;
    localparam int unsigned OPEN      = 4;

    function automatic logic is_onehot10(input logic [NUM_DIGITS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            n = n + {3'b000, v[i]};
        end
        return n == 4'd1;
    endfunction

    function automatic logic [3:0] encode10(input logic [NUM_DIGITS-1:0] v);
        logic [3:0] c;
        c = KEY_NONE;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (v[i]) begin
                c = 4'(i);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - 2-FF synchroniser plus tick-sampled stability filter
module debounce_channel
    import input_cond_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = STABLE_SAMPLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    input  logic sample_tick_i,
    output logic level_o
);

    localparam logic [3:0] CNT_LAST = 4'(STABLE_SAMPLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       level_q;
    logic       level_d;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive disagreeing ticks; flip the level on the last one.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sample_tick_i) begin
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_d = ~level_q;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end else begin
                cnt_d = 4'd0;
            end
        end
    end

    // Stability counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= 4'd0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced digit/button front end; INPUT_COND_AUTOREPEAT_EN adds backspace auto-repeat
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned TICK_CYCLES        = TICK_CYCLES_DEF,
    parameter int unsigned STABLE_SAMPLES     = STABLE_SAMPLES_DEF,
    parameter int unsigned REPEAT_DELAY_TICKS = 200,
    parameter int unsigned REPEAT_RATE_TICKS  = 40
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_DIGITS-1:0] nums_raw,
    input  logic                  set_btn_raw,
    input  logic                  confirm_btn_raw,
    input  logic                  backspace_btn_raw,
    input  logic                  admin_rst_btn_raw,
    input  logic                  open_sw_raw,
    output logic [NUM_DIGITS-1:0] nums_level,
    output logic                  key_valid,
    output logic [3:0]            key_code,
    output logic                  multi_key_err,
    output logic                  set_pulse,
    output logic                  confirm_pulse,
    output logic                  backspace_pulse,
    output logic                  admin_rst_pulse,
    output logic                  open_level
);

    localparam int unsigned        PRESC_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);

    logic [PRESC_W-1:0]       presc_q;
    logic [PRESC_W-1:0]       presc_d;
    logic                     sample_tick;

    logic [NUM_BTNS-1:0]      btn_raw;
    logic [NUM_BTNS-1:0]      btn_lvl;
    logic [NUM_DIGITS-1:0]    nums_lvl;

    logic [NUM_DIGITS-1:0]    nums_prev_q;
    logic [NUM_PULSE_BTN-1:0] btn_prev_q;
    logic [NUM_DIGITS-1:0]    nums_rise;
    logic [NUM_PULSE_BTN-1:0] btn_rise;

    logic                     key_valid_q;
    logic                     key_valid_d;
    logic [3:0]               key_code_q;
    logic [3:0]               key_code_d;
    logic                     multi_err_q;
    logic                     multi_err_d;
    logic [NUM_PULSE_BTN-1:0] pulse_q;
    logic [NUM_PULSE_BTN-1:0] pulse_d;
    logic                     rep_fire;

    // Shared prescaler: one sample_tick per TICK_CYCLES clocks.
    always_comb begin
        sample_tick = (presc_q == PRESC_LAST);
        presc_d     = sample_tick ? '0 : presc_q + PRESC_W'(1);
    end

    // Prescaler register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // Gather the button pins into one vector ordered by channel index.
    always_comb begin
        btn_raw            = '0;
        btn_raw[SET]       = set_btn_raw;
        btn_raw[CONFIRM]   = confirm_btn_raw;
        btn_raw[BACKSPACE] = backspace_btn_raw;
        btn_raw[ADMIN_RST] = admin_rst_btn_raw;
        btn_raw[OPEN]      = open_sw_raw;
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        debounce_channel #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_db (
            .clk          (clk),
            .rst_n        (rst_n),
            .raw_i        (nums_raw[g]),
            .sample_tick_i(sample_tick),
            .level_o      (nums_lvl[g])
        );
    end

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        debounce_channel #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_db (
            .clk          (clk),
            .rst_n        (rst_n),
            .raw_i        (btn_raw[g]),
            .sample_tick_i(sample_tick),
            .level_o      (btn_lvl[g])
        );
    end

`ifdef INPUT_COND_AUTOREPEAT_EN
    localparam int unsigned    REP_MAX    = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                                            REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
    localparam int unsigned    REP_W      = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY_TICKS - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE_TICKS - 1);

    logic [REP_W-1:0] rep_cnt_q;
    logic [REP_W-1:0] rep_cnt_d;
    logic             rep_armed_q;
    logic             rep_armed_d;

    // Count held ticks: first repeat after the delay, then one per rate period.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_fire    = 1'b0;
        if (!btn_lvl[BACKSPACE]) begin
            rep_cnt_d   = '0;
            rep_armed_d = 1'b0;
        end else if (sample_tick) begin
            if (rep_cnt_q == (rep_armed_q ? RATE_LAST : DELAY_LAST)) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = '0;
                rep_armed_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
        end
    end

    // Auto-repeat counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 1'b0;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Edge detection, one-hot validation and digit encoding.
    always_comb begin
        nums_rise   = nums_lvl & ~nums_prev_q;
        btn_rise    = btn_lvl[NUM_PULSE_BTN-1:0] & ~btn_prev_q;
        key_valid_d = (|nums_rise) & is_onehot10(nums_lvl);
        multi_err_d = (|nums_rise) & ~is_onehot10(nums_lvl);
        key_code_d  = key_valid_d ? encode10(nums_lvl) : KEY_NONE;
        pulse_d     = btn_rise;
        pulse_d[BACKSPACE] = btn_rise[BACKSPACE] | rep_fire;
    end

    // Previous-level and registered event outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nums_prev_q <= '0;
            btn_prev_q  <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= KEY_NONE;
            multi_err_q <= 1'b0;
            pulse_q     <= '0;
        end else begin
            nums_prev_q <= nums_lvl;
            btn_prev_q  <= btn_lvl[NUM_PULSE_BTN-1:0];
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            multi_err_q <= multi_err_d;
            pulse_q     <= pulse_d;
        end
    end

    assign nums_level      = nums_lvl;
    assign open_level      = btn_lvl[OPEN];
    assign key_valid       = key_valid_q;
    assign key_code        = key_code_q;
    assign multi_key_err   = multi_err_q;
    assign set_pulse       = pulse_q[SET];
    assign confirm_pulse   = pulse_q[CONFIRM];
    assign backspace_pulse = pulse_q[BACKSPACE];
    assign admin_rst_pulse = pulse_q[ADMIN_RST];

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage that feeds the lock controller with clean, single-cycle events. It synchronises, debounces and edge-detects the 10 digit switches and the five operator controls. It validates that exactly one digit switch is up and emits the digit as a 4-bit code. The lock FSM therefore consumes only synchronous pulses and levels, never raw pins.

## Interface
Parameters:
- TICK_CYCLES, 250000 — clk cycles per debounce sample tick (2.5 ms at 100 MHz).
- STABLE_SAMPLES, 4 — consecutive agreeing ticks needed to accept a new level (2..15).
- REPEAT_DELAY_TICKS, 200 — ticks before auto-repeat starts (only with macro).
- REPEAT_RATE_TICKS, 40 — ticks between repeats (only with macro).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset; all state clears immediately on assertion
- nums_raw  in  10  raw digit switches, bit i = digit i
- set_btn_raw, confirm_btn_raw, backspace_btn_raw, admin_rst_btn_raw  in  1 each  raw push buttons
- open_sw_raw  in  1  raw mode switch
- nums_level  out  10  debounced digit switch levels
- key_valid  out  1  one-cycle pulse: a new, valid single-digit press
- key_code  out  4  digit 0–9 while key_valid is high; 4'hF otherwise
- multi_key_err  out  1  one-cycle pulse: a digit rose while the resulting vector was not one-hot
- set_pulse, confirm_pulse, backspace_pulse, admin_rst_pulse  out  1 each  one-cycle rising-edge pulses
- open_level  out  1  debounced open switch level

## Operation
- Every raw input passes through a 2-FF synchroniser.
- One shared prescaler counts 0..TICK_CYCLES-1 and asserts sample_tick for one cycle at wrap.
- Per channel, on each sample_tick:
  - if the synchronised input differs from the debounced level, a stable counter increments;
  - when the counter reaches STABLE_SAMPLES the level flips and the counter clears;
  - if the input equals the level, the counter clears.
  - No tick means no change.
- Buttons: pulse = level & ~level_d (registered edge detect). Falling edges produce nothing.
- Digits: rise = nums_level & ~nums_level_d.
  - If rise ≠ 0 and nums_level has exactly one bit set: key_valid = 1 and key_code = its index.
  - If rise ≠ 0 and nums_level has zero or more than one bit set: multi_key_err = 1, no key_valid.
  - A digit falling, including one that leaves a one-hot vector, produces no event.
  - Two digits rising on the same tick produce multi_key_err.
- Button pulses are independent; several may assert in the same cycle.
- Levels reset to 0. A switch already up at reset is accepted after STABLE_SAMPLES ticks and does generate its event.

## Timing
- Reset values: nums_level = 0, key_valid = 0, key_code = 4'hF, multi_key_err = 0, all *_pulse = 0, open_level = 0. The prescaler and all counters are 0.
- Latency from raw input stable to level change: 2 cycles of sync, then STABLE_SAMPLES ticks, where the first tick arrives within TICK_CYCLES cycles.
- Pulses and key_valid/key_code assert exactly 1 cycle after the level register flips, and last exactly 1 cycle.
- A bounce shorter than STABLE_SAMPLES ticks never changes a level.
- A glitch on the raw input resets that channel's count at the next tick it is observed.
- rst_n asserted mid-count: counters, levels and edge registers clear asynchronously. No pulse is emitted on release.
- Prescaler wrap: TICK_CYCLES-1 → 0; the width is clog2(TICK_CYCLES).

## Configuration
- Macro INPUT_COND_AUTOREPEAT_EN.
- Defined:
  - backspace held with level 1 for REPEAT_DELAY_TICKS ticks after its edge pulse emits an extra backspace_pulse;
  - while still held, it emits another every REPEAT_RATE_TICKS ticks;
  - each repeat pulse lasts one cycle, aligned to the cycle after sample_tick;
  - release stops repeats and clears the repeat counter.
- Undefined: backspace behaves like every other button (edge only). The repeat counter and the REPEAT_* parameters have no effect.

## Structure
- Package input_cond_pkg holds:
  - default TICK_CYCLES and STABLE_SAMPLES;
  - KEY_NONE = 4'hF;
  - button channel index constants: SET, CONFIRM, BACKSPACE, ADMIN_RST, OPEN.
- Sub-module debounce_channel contains the synchroniser, the stable counter and the level register, with sample_tick as an input. It is instantiated 15 times.
- The prescaler, the one-hot check, the encoder, the edge detects and the auto-repeat logic live in the top module.

## Test plan
Bench parameters: TICK_CYCLES = 4, STABLE_SAMPLES = 3.
- Raw nums_raw = 10'b0000001000, held for 40 cycles → exactly one key_valid with key_code = 3, within 2 + 12 + 4 + 1 cycles; nums_level[3] = 1.
- confirm_btn_raw toggling every 3 cycles for 30 cycles, then held at 1 → no pulse during the bounce, exactly one confirm_pulse after it settles.
- Digit 5 held; digit 7 then raised → multi_key_err pulse, no key_valid; releasing 7 produces no event.
- Digits 2 and 4 raised in the same cycle → one multi_key_err, key_code remains 4'hF.
- rst_n pulsed low while a digit count is at 2 → all outputs return to their reset values at once; after release the digit is re-accepted with a single key_valid.
- With INPUT_COND_AUTOREPEAT_EN, REPEAT_DELAY_TICKS = 5 and REPEAT_RATE_TICKS = 2: backspace held for 60 ticks → 1 edge pulse plus (60-5)/2 + 1 repeats; none occur after release.
